// File: rtl/regfile_wb_scheduler_pkg.sv
// regfile_wb_scheduler_pkg: shared sizes and write-back requester indices
package regfile_wb_scheduler_pkg;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_DEPTH      = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REQ        = 3;
    localparam int REQ_ALU        = 0;
    localparam int REQ_LSU        = 1;
    localparam int REQ_MDU        = 2;
endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin grant searching upward from a rotating pointer
module rr_arbiter import regfile_wb_scheduler_pkg::*; #(
    parameter int NUM_REQ = regfile_wb_scheduler_pkg::NUM_REQ,
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               adv,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx
);
    logic [IW-1:0] ptr;
    // scan from farthest to nearest so the nearest requester wins
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                gnt = '0;
                gnt[(int'(ptr) + k) % NUM_REQ] = 1'b1;
                idx = IW'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (adv && |req)
            ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: shares the register file write port and tracks in-flight destinations
module regfile_wb_scheduler import regfile_wb_scheduler_pkg::*; #(
    parameter int DATA_WIDTH     = regfile_wb_scheduler_pkg::DATA_WIDTH,
    parameter int REG_DEPTH      = regfile_wb_scheduler_pkg::REG_DEPTH,
    parameter int REG_ADDR_WIDTH = regfile_wb_scheduler_pkg::REG_ADDR_WIDTH,
    parameter int NUM_REQ        = regfile_wb_scheduler_pkg::NUM_REQ
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              iss_valid,
    input  logic [REG_ADDR_WIDTH-1:0]         iss_rd,
    input  logic [REG_ADDR_WIDTH-1:0]         iss_rs1,
    input  logic [REG_ADDR_WIDTH-1:0]         iss_rs2,
    output logic                              iss_stall,
    input  logic [NUM_REQ-1:0]                wb_valid,
    input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     wb_data,
    output logic [NUM_REQ-1:0]                wb_ready,
    output logic                              rf_we,
    output logic [REG_ADDR_WIDTH-1:0]         rf_wa,
    output logic [DATA_WIDTH-1:0]             rf_wd,
    output logic [REG_DEPTH-1:0]              busy,
    output logic                              wb_err
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    logic [NUM_REQ-1:0]        gnt;
    logic [IW-1:0]             idx;
    logic                      xfer;
    logic                      accept;
    logic [REG_ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0]     wd;
    logic [REG_DEPTH-1:0]      set_mask;
    logic [REG_DEPTH-1:0]      clr_mask;
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk(clk),
        .rst(rst),
        .req(wb_valid),
        .adv(!rst),
        .gnt(gnt),
        .idx(idx)
    );
    assign wb_ready  = rst ? '0 : gnt;
    assign xfer      = |wb_ready;
    assign wa        = wb_addr[int'(idx)*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign wd        = wb_data[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    assign iss_stall = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]);
    assign accept    = iss_valid & !iss_stall;
    // set is OR-ed in after the clear so a same-edge issue keeps the register busy
    assign set_mask  = (accept && iss_rd != '0) ? REG_DEPTH'(1) << iss_rd : '0;
    assign clr_mask  = rf_we ? REG_DEPTH'(1) << rf_wa : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= '0;
            rf_we  <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
            wb_err <= 1'b0;
        end else begin
            busy  <= (busy & ~clr_mask) | set_mask;
            rf_we <= xfer && wa != '0;
            if (xfer) begin
                rf_wa <= wa;
                rf_wd <= wd;
            end
            if (xfer && wa != '0 && !busy[wa])
                wb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed and randomized checks against a behavioural scoreboard model
module tb_regfile_wb_scheduler;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int RD = 32;
    localparam int NR = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            iss_valid = 1'b0;
    logic [AW-1:0]   iss_rd = '0, iss_rs1 = '0, iss_rs2 = '0;
    logic            iss_stall;
    logic [NR-1:0]   wb_valid = '0;
    logic [NR*AW-1:0] wb_addr = '0;
    logic [NR*DW-1:0] wb_data = '0;
    logic [NR-1:0]   wb_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_wa;
    logic [DW-1:0]   rf_wd;
    logic [RD-1:0]   busy;
    logic            wb_err;

    regfile_wb_scheduler #(.DATA_WIDTH(DW), .REG_DEPTH(RD), .REG_ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_stall(iss_stall),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .busy(busy), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    bit [RD-1:0] m_busy;
    int          m_ptr;
    bit          m_we, m_err;
    bit [AW-1:0] m_wa;
    bit [DW-1:0] m_wd;
    bit          p_v[NR];
    bit [AW-1:0] p_a[NR];
    bit [DW-1:0] p_d[NR];
    logic [NR-1:0] s_ready;
    logic          s_stall;
    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock: drive requesters, check at negedge, advance the model past the posedge
    task automatic cycle();
        int g;
        bit e_stall;
        bit [RD-1:0] nb;
        bit n_we, n_err;
        bit [AW-1:0] n_wa;
        bit [DW-1:0] n_wd;
        int n_ptr;
        for (int i = 0; i < NR; i++) begin
            wb_valid[i] = p_v[i];
            wb_addr[i*AW +: AW] = p_a[i];
            wb_data[i*DW +: DW] = p_d[i];
        end
        @(negedge clk);
        g = -1;
        if (!rst)
            for (int k = 0; k < NR; k++)
                if (g < 0 && p_v[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        e_stall = iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd]);
        s_ready = wb_ready;
        s_stall = iss_stall;
        check("iss_stall", 64'(iss_stall), 64'(e_stall));
        check("wb_ready", 64'(wb_ready), g < 0 ? 64'd0 : 64'd1 << g);
        check("rf_we", 64'(rf_we), 64'(m_we));
        if (m_we) begin
            check("rf_wa", 64'(rf_wa), 64'(m_wa));
            check("rf_wd", 64'(rf_wd), 64'(m_wd));
        end
        check("busy", 64'(busy), 64'(m_busy));
        check("wb_err", 64'(wb_err), 64'(m_err));
        if (rst) begin
            nb = '0; n_we = 0; n_wa = '0; n_wd = '0; n_err = 0; n_ptr = 0;
        end else begin
            nb = m_busy;
            if (m_we) nb[m_wa] = 1'b0;
            if (iss_valid && !e_stall && iss_rd != 0) nb[iss_rd] = 1'b1;
            n_we = 0; n_wa = m_wa; n_wd = m_wd; n_err = m_err; n_ptr = m_ptr;
            if (g >= 0) begin
                n_we = p_a[g] != 0;
                n_wa = p_a[g];
                n_wd = p_d[g];
                n_ptr = (g + 1) % NR;
                if (p_a[g] != 0 && !m_busy[p_a[g]]) n_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_busy = nb; m_we = n_we; m_wa = n_wa; m_wd = n_wd; m_err = n_err; m_ptr = n_ptr;
        if (g >= 0) p_v[g] = 1'b0;
    endtask

    task automatic issue(input int rd, input int rs1, input int rs2);
        iss_valid = 1'b1;
        iss_rd = AW'(rd);
        iss_rs1 = AW'(rs1);
        iss_rs2 = AW'(rs2);
    endtask

    initial begin
        int exp_r[4] = '{1, 2, 4, 0};
        bit got;
        logic [RD-1:0] snap;
        for (int i = 0; i < NR; i++) begin p_v[i] = 1'b1; p_a[i] = AW'(i + 1); p_d[i] = $urandom; end
        // reset held with every requester valid
        cycle();
        cycle();
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wb_err", 64'(wb_err), 64'd0);
        check("rst_ready", 64'(s_ready), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) p_v[i] = 1'b0;
        // RAW stall released the cycle after the write
        issue(5, 0, 0);
        cycle();
        issue(6, 5, 0);
        cycle();
        check("raw_stall", 64'(s_stall), 64'd1);
        p_v[regfile_wb_scheduler_pkg::REQ_ALU] = 1'b1; p_a[0] = 5'd5; p_d[0] = 32'hDEADBEEF;
        cycle();
        check("raw_we", 64'(rf_we), 64'd1);
        check("raw_wa", 64'(rf_wa), 64'd5);
        check("raw_wd", 64'(rf_wd), 64'hDEADBEEF);
        cycle();
        check("raw_hold", 64'(s_stall), 64'd1);
        cycle();
        check("raw_release", 64'(s_stall), 64'd0);
        iss_valid = 1'b0;
        // round-robin from a fresh pointer
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int r = 1; r <= 3; r++) begin issue(r, 0, 0); cycle(); end
        iss_valid = 1'b0;
        for (int i = 0; i < NR; i++) begin p_v[i] = 1'b1; p_a[i] = AW'(i + 1); p_d[i] = $urandom; end
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("rr_ready", 64'(s_ready), 64'(exp_r[k]));
            if (k < 3) check("rr_wa", 64'(rf_wa), 64'(k + 1));
        end
        // fairness: LSU served while ALU keeps requesting
        issue(9, 0, 0);
        cycle();
        iss_valid = 1'b0;
        p_v[0] = 1'b1; p_a[0] = '0;
        cycle();
        p_v[0] = 1'b1; p_v[1] = 1'b1; p_a[1] = 5'd9; p_d[1] = $urandom;
        got = 1'b0;
        for (int k = 0; k < 2 && !got; k++) begin
            cycle();
            if (s_ready == 3'b010) got = 1'b1;
            p_v[0] = 1'b1;
        end
        check("lsu_fair", 64'(got), 64'd1);
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        cycle();
        // x0 consumed silently, then a write to a non-busy register
        snap = busy;
        p_v[0] = 1'b1; p_a[0] = '0; p_d[0] = $urandom;
        cycle();
        check("x0_we", 64'(rf_we), 64'd0);
        check("x0_busy", 64'(busy), 64'(snap));
        check("x0_taken", 64'(s_ready), 64'd1);
        p_v[1] = 1'b1; p_a[1] = 5'd7; p_d[1] = $urandom;
        cycle();
        check("err_we", 64'(rf_we), 64'd1);
        check("err_wa", 64'(rf_wa), 64'd7);
        check("err_flag", 64'(wb_err), 64'd1);
        // reset with x4 busy and an MDU transfer pending
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        issue(4, 0, 0);
        cycle();
        iss_valid = 1'b0;
        p_v[2] = 1'b1; p_a[2] = 5'd4; p_d[2] = $urandom;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_we", 64'(rf_we), 64'd0);
        p_v[0] = 1'b1; p_a[0] = '0;
        cycle();
        check("mid_ptr", 64'(s_ready), 64'd1);
        for (int i = 0; i < NR; i++) p_v[i] = 1'b0;
        cycle();
        // randomized traffic
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (1500) begin
            rst = ($urandom_range(0, 199) == 0);
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd = AW'($urandom_range(0, 9));
            iss_rs1 = AW'($urandom_range(0, 9));
            iss_rs2 = AW'($urandom_range(0, 9));
            for (int i = 0; i < NR; i++) begin
                if (!p_v[i] && $urandom_range(0, 2) == 0) begin
                    p_v[i] = 1'b1;
                    p_d[i] = $urandom;
                    p_a[i] = AW'($urandom_range(0, 9));
                    for (int t = 0; t < 4 && !m_busy[p_a[i]]; t++) p_a[i] = AW'($urandom_range(1, 9));
                end
            end
            cycle();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
